output_readback_dma: RTL and testbench

- Downstream consumer of the output memory's read port.
- On a start command it reads a contiguous word range out of the output memory and streams the words to the CPU/DMA fabric over a valid/ready interface.
- It hides the memory's 1-cycle registered read latency and absorbs downstream backpressure with a small skid FIFO.
- It signals completion with a done pulse, and rejects out-of-range commands with an error pulse.

---
 rtl/out_mem_pkg.sv | 14 +
 rtl/readback_fifo.sv | 53 +++++
 rtl/output_readback_dma.sv | 158 +++++++++++++++
 tb/tb_output_readback_dma.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_mem_pkg.sv
// Shared constants and FSM encoding for the output-memory readback path.
package out_mem_pkg;

    localparam int OUT_MEM_DEPTH = 301056;
    localparam int OUT_MEM_AW    = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } rdma_state_t;

endpackage

// File: rtl/readback_fifo.sv
// Small skid FIFO, first-word-fall-through; a push into an empty FIFO is
// visible on dout in the same cycle so the stream sees memory data with no extra stage.
module readback_fifo #(
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DW-1:0]                 din,
    output logic [DW-1:0]                 dout,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          empty
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          bypass, do_wr, do_rd;

    // Word arriving into an empty FIFO and consumed at once never gets stored.
    assign bypass = push && pop && (count_q == '0);
    assign do_wr  = push && !bypass;
    assign do_rd  = pop && (count_q != '0);

    assign empty = (count_q == '0) && !push;
    assign dout  = (count_q == '0) ? din : mem_q[rd_ptr_q];
    assign count = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/output_readback_dma.sv
// Streams a contiguous word range from the output memory to a valid/ready sink.
// Optional READBACK_CHECKSUM_EN adds a running 32-bit sum of delivered words.
module output_readback_dma
    import out_mem_pkg::*;
#(
    parameter int DEPTH      = OUT_MEM_DEPTH,
    parameter int AW         = OUT_MEM_AW,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_start,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW-1:0] cmd_len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] mem_rd_addr,
    output logic          mem_rd_en,
    input  logic [31:0]   mem_rd_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [31:0]   m_data,
    output logic          m_last
`ifdef READBACK_CHECKSUM_EN
    ,
    output logic [31:0]   checksum
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rdma_state_t   state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] sent_q, sent_d;
    logic [AW-1:0] last_addr_q, last_addr_d;
    logic          inflight_q;
    logic          err_q, err_d;

    logic [AW:0]   end_addr;
    logic          cmd_bad, accept, issue, hs;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          fifo_empty;
    logic [31:0]   fifo_dout;

    assign end_addr    = {1'b0, cmd_base} + {1'b0, cmd_len};
    assign cmd_bad     = end_addr > (AW+1)'(DEPTH);
    assign accept      = (state_q == IDLE) && cmd_start && !cmd_bad;
    // Reads in flight hold a FIFO slot, so the FIFO can never overflow.
    assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign issue       = (state_q == RUN) && (rem_q != '0) &&
                         (credit_used < (CW+1)'(FIFO_DEPTH));
    assign hs          = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (cmd_len == '0) ? FIN : RUN;
            RUN:     if (issue && (rem_q == AW'(1))) state_d = DRAIN;
            DRAIN:   if (hs && m_last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == RUN) || (state_q == DRAIN);
        done        = (state_q == FIN);
        err         = err_q;
        mem_rd_en   = issue;
        mem_rd_addr = issue ? addr_q : last_addr_q;
    end

    always_comb begin
        addr_d      = addr_q;
        rem_d       = rem_q;
        len_d       = len_q;
        sent_d      = sent_q;
        last_addr_d = last_addr_q;
        err_d       = (state_q == IDLE) && cmd_start && cmd_bad;
        if (accept) begin
            addr_d = cmd_base;
            rem_d  = cmd_len;
            len_d  = cmd_len;
            sent_d = '0;
        end
        if (issue) begin
            last_addr_d = addr_q;
            addr_d      = addr_q + AW'(1);
            rem_d       = rem_q - AW'(1);
        end
        if (hs) sent_d = sent_q + AW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            rem_q       <= '0;
            len_q       <= '0;
            sent_q      <= '0;
            last_addr_q <= '0;
            inflight_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            len_q       <= len_d;
            sent_q      <= sent_d;
            last_addr_q <= last_addr_d;
            inflight_q  <= issue;
            err_q       <= err_d;
        end
    end

    readback_fifo #(
        .DW         (32),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .pop   (hs),
        .din   (mem_rd_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? fifo_dout : '0;
    assign m_last  = m_valid && (sent_q == len_q - AW'(1));

`ifdef READBACK_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == IDLE) && cmd_start && !cmd_bad) csum_d = '0;
        else if (hs)                                    csum_d = csum_q + m_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_output_readback_dma.sv
// Directed bench for output_readback_dma with a queue-based word scoreboard.
module tb_output_readback_dma;
    import out_mem_pkg::*;

    localparam int DEPTH = OUT_MEM_DEPTH;
    localparam int AW    = OUT_MEM_AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_start = 1'b0;
    logic [AW-1:0] cmd_base = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          busy, done, err, mem_rd_en, m_valid, m_last;
    logic [AW-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_data = '0;
    logic          m_ready = 1'b0;
    logic [31:0]   m_data;
`ifdef READBACK_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    output_readback_dma dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_start   (cmd_start),
        .cmd_base    (cmd_base),
        .cmd_len     (cmd_len),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last)
`ifdef READBACK_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int mem_mode = 0;
    int hs_total = 0;
    logic [32:0] exp_q[$];
    logic [32:0] sb_e;
    logic        stall_q = 1'b0;
    logic [31:0] stall_data = '0;
    logic        stall_last = 1'b0;

    int r_t0, r_first_v, r_first_w, r_done, r_err, r_err_n;
    int r_busy_n, r_busy_first, r_busy_last, r_rd_n, r_last_addr, r_words;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input int a);
        return (mem_mode == 1) ? 32'hFFFF_FFFF : 32'(a);
    endfunction

    // Memory with a one-cycle registered read port.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rd_data <= memf(int'(mem_rd_addr));
    end

    // Scoreboard: every handshaken word must be the next expected word.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, stall_data);
                chk("stall_last", m_last, stall_last);
            end
            if (m_valid && m_ready) begin
                hs_total++;
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: got %0d expected none", m_data);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (m_data !== sb_e[31:0] || m_last !== sb_e[32]) begin
                        fails++;
                        $display("FAIL word: got data %0d last %0d expected data %0d last %0d",
                                 m_data, m_last, sb_e[31:0], sb_e[32]);
                    end
                end
            end
            if (!m_valid) chk("idle_last", m_last, 0);
            if (mem_rd_en) chk("addr_range", mem_rd_addr < AW'(DEPTH), 1);
            chk("fifo_bound", dut.u_fifo.count <= 3'd4, 1);
            stall_q    = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
        end
    end

    // mode 0: m_ready held high; mode 1: m_ready toggles 1,0,1,0...
    task automatic run_cmd(input int base, input int len, input int mode,
                           input int max_cyc, input int restart_at);
        @(posedge clk); #1;
        cmd_base = AW'(base);
        cmd_len  = AW'(len);
        cmd_start = 1'b1;
        m_ready  = 1'b1;
        r_t0 = cyc; r_first_v = -1; r_first_w = -1; r_done = -1; r_err = -1;
        r_err_n = 0; r_busy_n = 0; r_busy_first = -1; r_busy_last = -1;
        r_rd_n = 0; r_last_addr = -1; r_words = 0;
        if (base + len <= DEPTH)
            for (int k = 0; k < len; k++) exp_q.push_back({k == len - 1, memf(base + k)});
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (busy) begin
                r_busy_n++;
                if (r_busy_first < 0) r_busy_first = cyc;
                r_busy_last = cyc;
            end
            if (m_valid && r_first_v < 0) begin
                r_first_v = cyc;
                r_first_w = int'(m_data);
            end
            if (m_valid && m_ready) r_words++;
            if (mem_rd_en) begin
                r_rd_n++;
                r_last_addr = int'(mem_rd_addr);
            end
            if (err) begin
                r_err = cyc;
                r_err_n++;
            end
            if (done) begin
                r_done = cyc;
                break;
            end
            @(posedge clk); #1;
            cmd_start = (i + 1 == restart_at);
            if (cmd_start) begin
                cmd_base = '0;
                cmd_len  = AW'(1);
            end
            m_ready = (mode == 0) ? 1'b1 : ((i + 1) % 2 == 0);
        end
        @(posedge clk); #1;
        cmd_start = 1'b0;
        m_ready   = 1'b1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_rd_en"}, mem_rd_en, 0);
        chk({nm, "_rd_addr"}, mem_rd_addr, 0);
        chk({nm, "_valid"}, m_valid, 0);
        chk({nm, "_last"}, m_last, 0);
        chk({nm, "_data"}, m_data, 0);
`ifdef READBACK_CHECKSUM_EN
        chk({nm, "_checksum"}, checksum, 0);
`endif
    endtask

    initial begin
        int h0;
        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ready = 1'b1;

        // base=100 len=5, sink always ready
        run_cmd(100, 5, 0, 30, -1);
        chk("A_first_valid", r_first_v, r_t0 + 2);
        chk("A_first_word", r_first_w, 100);
        chk("A_done", r_done, r_t0 + 7);
        chk("A_busy_first", r_busy_first, r_t0 + 1);
        chk("A_busy_last", r_busy_last, r_t0 + 6);
        chk("A_busy_n", r_busy_n, 6);
        chk("A_rd_n", r_rd_n, 5);
        chk("A_last_addr", r_last_addr, 104);
        chk("A_words", r_words, 5);
        @(negedge clk);
        chk("A_done_pulse", done, 0);
        chk("A_busy_after", busy, 0);
        chk("A_sb_empty", exp_q.size(), 0);

        // base=0 len=8, sink toggling
        run_cmd(0, 8, 1, 80, -1);
        chk("B_done_seen", r_done >= 0, 1);
        chk("B_words", r_words, 8);
        chk("B_rd_n", r_rd_n, 8);
        chk("B_first_word", r_first_w, 0);
        chk("B_sb_empty", exp_q.size(), 0);

        // Range end past DEPTH is rejected
        run_cmd(301050, 7, 0, 6, -1);
        chk("C_err_at", r_err, r_t0 + 1);
        chk("C_err_n", r_err_n, 1);
        chk("C_rd_n", r_rd_n, 0);
        chk("C_busy_n", r_busy_n, 0);
        chk("C_no_done", r_done, -1);

        // Range ending exactly at DEPTH is legal
        run_cmd(301050, 6, 0, 30, -1);
        chk("D_done", r_done, r_t0 + 8);
        chk("D_last_addr", r_last_addr, 301055);
        chk("D_rd_n", r_rd_n, 6);
        chk("D_err_n", r_err_n, 0);
        chk("D_sb_empty", exp_q.size(), 0);

        // Zero-length command
        run_cmd(33, 0, 0, 10, -1);
        chk("E_done", r_done, r_t0 + 1);
        chk("E_no_valid", r_first_v, -1);
        chk("E_rd_n", r_rd_n, 0);
        chk("E_busy_n", r_busy_n, 0);

        // Second start during a transfer is ignored
        run_cmd(200, 10, 0, 40, 3);
        chk("F_done", r_done, r_t0 + 12);
        chk("F_words", r_words, 10);
        chk("F_err_n", r_err_n, 0);
        chk("F_rd_n", r_rd_n, 10);
        chk("F_last_addr", r_last_addr, 209);
        chk("F_sb_empty", exp_q.size(), 0);

        // Reset after 3 of 10 words
        @(posedge clk); #1;
        cmd_base = AW'(50);
        cmd_len  = AW'(10);
        cmd_start = 1'b1;
        m_ready  = 1'b1;
        h0 = hs_total;
        for (int k = 0; k < 10; k++) exp_q.push_back({k == 9, memf(50 + k)});
        @(posedge clk); #1;
        cmd_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (hs_total - h0 >= 3) break;
        end
        chk("G_three_words", hs_total - h0, 3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("G_async");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("G_rst_done", done, 0);
            chk("G_rst_valid", m_valid, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("G_post_done", done, 0);
            chk("G_post_busy", busy, 0);
        end

        // Normal operation after reset
        run_cmd(20, 2, 0, 20, -1);
        chk("H_first_valid", r_first_v, r_t0 + 2);
        chk("H_first_word", r_first_w, 20);
        chk("H_done", r_done, r_t0 + 4);
        chk("H_words", r_words, 2);
        chk("H_sb_empty", exp_q.size(), 0);

`ifdef READBACK_CHECKSUM_EN
        mem_mode = 1;
        run_cmd(0, 3, 0, 20, -1);
        chk("K_done", r_done, r_t0 + 5);
        chk("K_checksum", checksum, 32'hFFFF_FFFD);
        @(negedge clk);
        @(negedge clk);
        chk("K_checksum_hold", checksum, 32'hFFFF_FFFD);
        mem_mode = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
